// File: rtl/huffman_stream_decoder.sv
// rtl/huffman_stream_decoder.sv - serial MSB-first Huffman codeword decoder for leaves A..D
module huffman_stream_decoder #(
  parameter int MAXLEN = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              table_load,
  input  logic [MAXLEN-1:0] code_A,
  input  logic [MAXLEN-1:0] code_B,
  input  logic [MAXLEN-1:0] code_C,
  input  logic [MAXLEN-1:0] code_D,
  input  logic [2:0]        len_A,
  input  logic [2:0]        len_B,
  input  logic [2:0]        len_C,
  input  logic [2:0]        len_D,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [3:0]        sym_id,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic              err,
  output logic [11:0]       sym_count
);

  typedef enum logic {NOTABLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t            state, state_next;
  logic [MAXLEN-1:0] sr, sr_next;
  logic [2:0]        cnt, cnt_next;
  logic [MAXLEN-1:0] code_a_r, code_b_r, code_c_r, code_d_r;
  logic [2:0]        len_a_r, len_b_r, len_c_r, len_d_r;
  logic [3:0]        hit;
  logic              any_hit;
  logic [3:0]        match_id;
  logic              accept;

  // Low len bits set; a length above MAXLEN can never equal cnt_next, so it never matches.
  function automatic logic [MAXLEN-1:0] len_mask(input logic [2:0] l);
    logic [MAXLEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAXLEN; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  // A leaf matches only on the exact bit count equal to its length (len 0 never, since cnt_next >= 1).
  function automatic logic leaf_hit(input logic [2:0] l, input logic [MAXLEN-1:0] c,
                                    input logic [MAXLEN-1:0] s, input logic [2:0] n);
    return (l == n) && (((s ^ c) & len_mask(l)) == '0);
  endfunction

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= NOTABLE;
    else       state <= state_next;
  end

  // Next state: the first table load arms the decoder; it then stays in COLLECT
  always_comb begin
    state_next = state;
    if (table_load) state_next = COLLECT;
  end

  // Output decode: accept bits only with a loaded table and a free output slot, never during a load
  always_comb begin
    bit_ready = 1'b0;
    if (state == COLLECT && !table_load) bit_ready = !sym_valid || sym_ready;
  end

  // Candidate shift state and per-leaf match with A > B > C > D priority
  always_comb begin
    accept   = bit_valid && bit_ready;
    sr_next  = {sr[MAXLEN-2:0], bit_in};
    cnt_next = cnt + 3'd1;
    hit[0]   = leaf_hit(len_a_r, code_a_r, sr_next, cnt_next);
    hit[1]   = leaf_hit(len_b_r, code_b_r, sr_next, cnt_next);
    hit[2]   = leaf_hit(len_c_r, code_c_r, sr_next, cnt_next);
    hit[3]   = leaf_hit(len_d_r, code_d_r, sr_next, cnt_next);
    any_hit  = |hit;
    match_id = 4'b1101;
    if (hit[0])      match_id = 4'b1010;
    else if (hit[1]) match_id = 4'b1011;
    else if (hit[2]) match_id = 4'b1100;
  end

  // Table latch, bit accumulation, symbol emission, error pulse and hand-off counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sr        <= '0;
      cnt       <= '0;
      sym_id    <= '0;
      sym_valid <= 1'b0;
      err       <= 1'b0;
      sym_count <= '0;
      code_a_r  <= '0;
      code_b_r  <= '0;
      code_c_r  <= '0;
      code_d_r  <= '0;
      len_a_r   <= '0;
      len_b_r   <= '0;
      len_c_r   <= '0;
      len_d_r   <= '0;
    end else begin
      err <= 1'b0;
      if (table_load) begin
        // A reload drops any partial codeword and any unclaimed symbol.
        code_a_r  <= code_A;
        code_b_r  <= code_B;
        code_c_r  <= code_C;
        code_d_r  <= code_D;
        len_a_r   <= len_A;
        len_b_r   <= len_B;
        len_c_r   <= len_C;
        len_d_r   <= len_D;
        sr        <= '0;
        cnt       <= '0;
        sym_valid <= 1'b0;
      end else begin
        if (sym_valid && sym_ready) begin
          sym_count <= sym_count + 12'd1;
          sym_valid <= 1'b0;
        end
        if (accept) begin
          if (any_hit) begin
            sym_id    <= match_id;
            sym_valid <= 1'b1;
            sr        <= '0;
            cnt       <= '0;
          end else if (cnt_next == 3'(MAXLEN)) begin
            err <= 1'b1;
            sr  <= '0;
            cnt <= '0;
          end else begin
            sr  <= sr_next;
            cnt <= cnt_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_huffman_stream_decoder.sv
// tb/tb_huffman_stream_decoder.sv - directed self-checking bench for huffman_stream_decoder
module tb_huffman_stream_decoder;

  logic        CLK;
  logic        nRST;
  logic        table_load;
  logic [3:0]  code_A, code_B, code_C, code_D;
  logic [2:0]  len_A, len_B, len_C, len_D;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic [3:0]  sym_id;
  logic        sym_valid;
  logic        sym_ready;
  logic        err;
  logic [11:0] sym_count;

  int checks = 0;
  int errors = 0;

  huffman_stream_decoder #(.MAXLEN(4)) dut (
    .CLK(CLK), .nRST(nRST), .table_load(table_load),
    .code_A(code_A), .code_B(code_B), .code_C(code_C), .code_D(code_D),
    .len_A(len_A), .len_B(len_B), .len_C(len_C), .len_D(len_D),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_id(sym_id), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .err(err), .sym_count(sym_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset;
    @(posedge CLK);
    #1;
    nRST = 1'b0; table_load = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b1;
    #2;
    nRST = 1'b1;
    tick();
  endtask

  task automatic load_table(input logic [3:0] ca, cb, cc, cd, input logic [2:0] la, lb, lc, ld);
    code_A = ca; code_B = cb; code_C = cc; code_D = cd;
    len_A = la; len_B = lb; len_C = lc; len_D = ld;
    table_load = 1'b1;
    tick();
    table_load = 1'b0;
  endtask

  task automatic load_first;
    load_table(4'b0000, 4'b0010, 4'b0110, 4'b0111, 3'd1, 3'd2, 3'd3, 3'd3);
  endtask

  task automatic send_bit(input logic b);
    bit_in = b; bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic test_reset;
    nRST = 1'b0; table_load = 1'b0; bit_valid = 1'b1; bit_in = 1'b0; sym_ready = 1'b1;
    code_A = '0; code_B = '0; code_C = '0; code_D = '0;
    len_A = '0; len_B = '0; len_C = '0; len_D = '0;
    #12;
    checks++;
    if ({sym_valid, sym_id, err, sym_count, bit_ready} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b id=%h err=%b cnt=%h rdy=%b want all 0",
               sym_valid, sym_id, err, sym_count, bit_ready);
    end
    bit_valid = 1'b0;
    apply_reset();
  endtask

  task automatic test_basic_stream;
    logic [8:0] bits;
    logic [8:0] exp_v;
    logic [3:0] exp_id [9];
    bits  = 9'b010110111;
    exp_v = 9'b101001001;
    exp_id = '{4'hA, 4'h0, 4'hB, 4'h0, 4'h0, 4'hC, 4'h0, 4'h0, 4'hD};
    apply_reset();
    load_first();
    sym_ready = 1'b1;
    bit_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bit_in = bits[8-i];
      tick();
      checks++;
      if (sym_valid !== exp_v[8-i] || err !== 1'b0 || (exp_v[8-i] && sym_id !== exp_id[i])) begin
        errors++;
        $display("FAIL basic_bit%0d got v=%b id=%h err=%b want v=%b id=%h err=0",
                 i, sym_valid, sym_id, err, exp_v[8-i], exp_id[i]);
      end
    end
    bit_valid = 1'b0;
    tick();
    checks++;
    if (sym_count !== 12'd4 || sym_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_count got cnt=%0d v=%b want cnt=4 v=0", sym_count, sym_valid);
    end
  endtask

  task automatic test_backpressure;
    apply_reset();
    load_first();
    sym_ready = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if (sym_valid !== 1'b1 || sym_id !== 4'hC) begin
      errors++;
      $display("FAIL bp_match got v=%b id=%h want v=1 id=c", sym_valid, sym_id);
    end
    bit_valid = 1'b1; bit_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bit_ready !== 1'b0 || sym_valid !== 1'b1 || sym_id !== 4'hC || sym_count !== 12'd0) begin
        errors++;
        $display("FAIL bp_hold%0d got rdy=%b v=%b id=%h cnt=%0d want rdy=0 v=1 id=c cnt=0",
                 i, bit_ready, sym_valid, sym_id, sym_count);
      end
      tick();
    end
    bit_valid = 1'b0;
    sym_ready = 1'b1;
    tick();
    checks++;
    if (sym_count !== 12'd1 || sym_valid !== 1'b0 || bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got cnt=%0d v=%b rdy=%b want cnt=1 v=0 rdy=1",
               sym_count, sym_valid, bit_ready);
    end
  endtask

  task automatic test_error;
    logic [3:0] exp_err;
    exp_err = 4'b0001;
    apply_reset();
    load_table(4'b0000, 4'b0001, 4'b0010, 4'b0110, 3'd2, 3'd2, 3'd2, 3'd3);
    sym_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1);
      checks++;
      if (err !== exp_err[3-i] || sym_valid !== 1'b0) begin
        errors++;
        $display("FAIL err_bit%0d got err=%b v=%b want err=%b v=0", i, err, sym_valid, exp_err[3-i]);
      end
    end
    send_bit(1'b0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse_len got err=%b want 0", err);
    end
    send_bit(1'b1);
    checks++;
    if (sym_valid !== 1'b1 || sym_id !== 4'hB) begin
      errors++;
      $display("FAIL err_recover got v=%b id=%h want v=1 id=b", sym_valid, sym_id);
    end
  endtask

  task automatic test_notable;
    apply_reset();
    bit_valid = 1'b1; bit_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bit_ready !== 1'b0 || sym_valid !== 1'b0 || sym_count !== 12'd0 || err !== 1'b0) begin
        errors++;
        $display("FAIL notable%0d got rdy=%b v=%b cnt=%0d err=%b want all 0",
                 i, bit_ready, sym_valid, sym_count, err);
      end
      tick();
    end
    bit_valid = 1'b0;
    load_first();
    send_bit(1'b0);
    checks++;
    if (sym_valid !== 1'b1 || sym_id !== 4'hA) begin
      errors++;
      $display("FAIL notable_then_load got v=%b id=%h want v=1 id=a", sym_valid, sym_id);
    end
  endtask

  task automatic test_reload;
    apply_reset();
    load_first();
    sym_ready = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    bit_valid = 1'b1; bit_in = 1'b1;
    code_A = 4'b0000; code_B = 4'b0010; code_C = 4'b0110; code_D = 4'b0111;
    len_A = 3'd1; len_B = 3'd2; len_C = 3'd3; len_D = 3'd3;
    table_load = 1'b1;
    #1;
    checks++;
    if (bit_ready !== 1'b0) begin
      errors++;
      $display("FAIL reload_ready got %b want 0", bit_ready);
    end
    tick();
    table_load = 1'b0;
    bit_valid = 1'b0;
    send_bit(1'b0);
    checks++;
    if (sym_valid !== 1'b1 || sym_id !== 4'hA) begin
      errors++;
      $display("FAIL reload_partial got v=%b id=%h want v=1 id=a", sym_valid, sym_id);
    end
    sym_ready = 1'b0;
    load_first();
    checks++;
    if (sym_valid !== 1'b0 || sym_count !== 12'd0) begin
      errors++;
      $display("FAIL reload_pending got v=%b cnt=%0d want v=0 cnt=0", sym_valid, sym_count);
    end
    sym_ready = 1'b1;
  endtask

  task automatic test_async_reset;
    apply_reset();
    load_first();
    sym_ready = 1'b1;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    checks++;
    if (sym_count !== 12'd2) begin
      errors++;
      $display("FAIL arst_pre got cnt=%0d want 2", sym_count);
    end
    bit_valid = 1'b1; bit_in = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if ({sym_valid, sym_id, err, sym_count, bit_ready} !== 19'd0) begin
      errors++;
      $display("FAIL arst_outputs got v=%b id=%h err=%b cnt=%h rdy=%b want all 0",
               sym_valid, sym_id, err, sym_count, bit_ready);
    end
    #1;
    nRST = 1'b1;
    tick();
    checks++;
    if (bit_ready !== 1'b0 || sym_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_notable got rdy=%b v=%b want rdy=0 v=0", bit_ready, sym_valid);
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_back_to_back_wrap;
    apply_reset();
    load_first();
    sym_ready = 1'b1;
    bit_valid = 1'b1; bit_in = 1'b0;
    for (int i = 0; i < 4096; i++) tick();
    checks++;
    if (sym_count !== 12'hfff || sym_valid !== 1'b1 || sym_id !== 4'hA) begin
      errors++;
      $display("FAIL wrap_pre got cnt=%h v=%b id=%h want cnt=fff v=1 id=a", sym_count, sym_valid, sym_id);
    end
    bit_valid = 1'b0;
    tick();
    checks++;
    if (sym_count !== 12'h000 || sym_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_post got cnt=%h v=%b want cnt=000 v=0", sym_count, sym_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_error();
    test_notable();
    test_reload();
    test_async_reset();
    test_back_to_back_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
